// File: rtl/sc_sched_pkg.sv
// Shared types and helpers for the SC decoding schedule generator.
// Provides the FSM state type, default code geometry and stage cycle count.
package sc_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N_LOG_DEF = 3;
  localparam int P_LOG_DEF = 1;
  localparam int N  = 1 << N_LOG_DEF;
  localparam int SW = (N_LOG_DEF - 1 - P_LOG_DEF > 1) ? (N_LOG_DEF - 1 - P_LOG_DEF) : 1;

  function automatic int sub_width(input int n_log, input int p_log);
    return (n_log - 1 - p_log > 1) ? (n_log - 1 - p_log) : 1;
  endfunction

  // Cycles needed by stage s, minus one (a stage no wider than the PE array takes one cycle).
  function automatic int stage_cycles(input int s, input int p_log);
    return (s > p_log) ? ((1 << (s - p_log)) - 1) : 0;
  endfunction

endpackage

// File: rtl/sc_tz_count.sv
// Combinational trailing-zero count of an N_LOG-bit value; zero input yields N_LOG-1.
module sc_tz_count #(
  parameter int N_LOG = 3
) (
  input  logic [N_LOG-1:0]         value,
  output logic [$clog2(N_LOG)-1:0] count
);

  localparam int CW = $clog2(N_LOG);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    count = CW'(N_LOG - 1);
    for (int i = N_LOG - 1; i >= 0; i--) begin
      if (value[i]) count = CW'(i);
    end
  end

endmodule

// File: rtl/sc_schedule_generator.sv
// Walks the SC decoding tree bit by bit, presenting one registered (stage, bit, slice, f/g) step per unstalled cycle.
// First step appears the cycle after start; stall holds the step and drops pe_valid; done pulses one cycle after the last step.
module sc_schedule_generator
  import sc_sched_pkg::*;
#(
  parameter int N_LOG = N_LOG_DEF,
  parameter int P_LOG = P_LOG_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                stall,
  output logic                                ready,
  output logic                                busy,
  output logic                                done,
  output logic                                pe_valid,
  output logic [$clog2(N_LOG)-1:0]            stage_index,
  output logic [N_LOG-1:0]                    bit_index,
  output logic [sub_width(N_LOG, P_LOG)-1:0]  sub_index,
  output logic                                fg_sel
);

  localparam int STW = $clog2(N_LOG);
  localparam int SWL = sub_width(N_LOG, P_LOG);
  localparam logic [STW-1:0] ROOT = STW'(N_LOG - 1);

  state_t           state;
  logic [N_LOG-1:0] bit_next;
  logic [STW-1:0]   next_tz;
  logic [STW-1:0]   stage_dn;
  logic             last_sub;

  assign bit_next = bit_index + N_LOG'(1);
  assign stage_dn = stage_index - STW'(1);
  assign last_sub = (sub_index == SWL'(stage_cycles(int'(stage_index), P_LOG)));
  assign pe_valid = busy & ~stall;

  sc_tz_count #(.N_LOG(N_LOG)) u_tz (
    .value (bit_next),
    .count (next_tz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      stage_index <= ROOT;
      bit_index   <= '0;
      sub_index   <= '0;
      fg_sel      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            if (!last_sub) begin
              sub_index <= sub_index + SWL'(1);
            end else if (stage_index != '0) begin
              stage_index <= stage_dn;
              sub_index   <= '0;
              fg_sel      <= bit_index[stage_dn];
            end else if (!(&bit_index)) begin
              // The new bit's start stage is its lowest set bit, so it always opens with g.
              bit_index   <= bit_next;
              stage_index <= next_tz;
              sub_index   <= '0;
              fg_sel      <= 1'b1;
            end else begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              stage_index <= ROOT;
              bit_index   <= '0;
              sub_index   <= '0;
              fg_sel      <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_schedule_generator.sv
// Directed bench: a nested-loop schedule model fills scoreboards that are drained as each DUT presents steps.
module tb_sc_schedule_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic start0 = 1'b0;
  logic stall0 = 1'b0;

  logic       ready, busy, done, pe_valid, fg_sel;
  logic [1:0] stage_index;
  logic [2:0] bit_index;
  logic [0:0] sub_index;

  logic       ready0, busy0, done0, pe_valid0, fg_sel0;
  logic [1:0] stage_index0;
  logic [2:0] bit_index0;
  logic [1:0] sub_index0;

  typedef struct {
    int st;
    int bi;
    int sb;
    int fg;
  } step_t;

  step_t q1[$];
  step_t q0[$];

  int checks = 0;
  int errors = 0;
  int valid_cnt, run_cycles, done_cnt;
  int valid0_cnt, run0_cycles, done0_cnt;

  sc_schedule_generator #(.N_LOG(3), .P_LOG(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .ready(ready), .busy(busy), .done(done), .pe_valid(pe_valid),
    .stage_index(stage_index), .bit_index(bit_index), .sub_index(sub_index), .fg_sel(fg_sel)
  );

  sc_schedule_generator #(.N_LOG(3), .P_LOG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stall(stall0),
    .ready(ready0), .busy(busy0), .done(done0), .pe_valid(pe_valid0),
    .stage_index(stage_index0), .bit_index(bit_index0), .sub_index(sub_index0), .fg_sel(fg_sel0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tz(input int v);
    int t = 0;
    while (((v >> t) & 1) == 0 && t < 3) t++;
    return t;
  endfunction

  // Independent model: for each bit, every stage from its start stage down, each split into slices.
  task automatic push_sched(input int pl, input bit to0);
    step_t e;
    int ss, c;
    for (int i = 0; i < 8; i++) begin
      ss = (i == 0) ? 2 : tz(i);
      for (int s = ss; s >= 0; s--) begin
        c = (s > pl) ? (1 << (s - pl)) : 1;
        for (int k = 0; k < c; k++) begin
          e.st = s; e.bi = i; e.sb = k; e.fg = (s == ss && i > 0) ? 1 : 0;
          if (to0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  endtask

  task automatic tick(input logic st, input logic sl);
    step_t e;
    @(negedge clk);
    start = st;
    stall = sl;
    #1;
    if (busy) run_cycles++;
    if (done) done_cnt++;
    if (sl) chk("p1_stall_gate", pe_valid, 0);
    if (busy && q1.size() > 0) begin
      e = q1[0];
      chk("p1_stage", stage_index, e.st);
      chk("p1_bit", bit_index, e.bi);
      chk("p1_sub", sub_index, e.sb);
      chk("p1_fg", fg_sel, e.fg);
      if (pe_valid) begin
        void'(q1.pop_front());
        valid_cnt++;
      end
    end else if (busy) begin
      chk("p1_extra_step", pe_valid, 0);
    end
    if (busy0) run0_cycles++;
    if (done0) done0_cnt++;
    if (busy0 && q0.size() > 0) begin
      e = q0[0];
      chk("p0_stage", stage_index0, e.st);
      chk("p0_bit", bit_index0, e.bi);
      chk("p0_sub", sub_index0, e.sb);
      chk("p0_fg", fg_sel0, e.fg);
      if (pe_valid0) begin
        void'(q0.pop_front());
        valid0_cnt++;
      end
    end else if (busy0) begin
      chk("p0_extra_step", pe_valid0, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pe_valid"}, pe_valid, 0);
    chk({tag, "_stage"}, stage_index, 2);
    chk({tag, "_bit"}, bit_index, 0);
    chk({tag, "_sub"}, sub_index, 0);
    chk({tag, "_fg"}, fg_sel, 0);
  endtask

  // One run on the P_LOG=1 instance; optional stall window, mid-run reset, or stray start pulses.
  task automatic do_run(input int stall_at, input int stall_n, input int rst_at, input bit poke, input int exp_cycles);
    int c, stalled;
    bit fin;
    logic sl, st;
    valid_cnt = 0; run_cycles = 0; done_cnt = 0; stalled = 0; fin = 0; c = 0;
    push_sched(1, 0);
    tick(1'b1, 1'b0);
    chk("start_cycle_ready", ready, 1);
    chk("start_cycle_busy", busy, 0);
    while (!fin && c < 200) begin
      sl = (valid_cnt == stall_at && stalled < stall_n);
      st = poke && (valid_cnt == 3 || valid_cnt == 16);
      if (poke && valid_cnt == 16) sl = 1'b1;
      tick(st, sl);
      if (sl) stalled++;
      c++;
      if (rst_at >= 0 && valid_cnt == rst_at) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrun_rst");
        q1.delete();
        fin = 1;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle_ready", ready, 1);
      end else if (done_cnt > 0) begin
        fin = 1;
        chk("done_busy", busy, 0);
        chk("done_ready", ready, 0);
        chk("run_steps", valid_cnt, 16);
        chk("run_cycles", run_cycles, exp_cycles);
        chk("run_queue_left", q1.size(), 0);
      end
    end
    if (!fin) chk("run_timeout", fin, 1);
  endtask

  initial begin
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset");
    chk("reset_p0_ready", ready0, 1);
    chk("reset_p0_stage", stage_index0, 2);
    @(negedge clk);
    rst = 1'b0;

    do_run(-1, 0, -1, 1'b0, 16);
    do_run(5, 3, -1, 1'b0, 19);
    do_run(-1, 0, -1, 1'b1, 16);
    do_run(-1, 0, -1, 1'b0, 16);
    do_run(-1, 0, 10, 1'b0, 16);
    do_run(-1, 0, -1, 1'b0, 16);
    tick(1'b0, 1'b0);
    chk("final_idle_ready", ready, 1);
    chk("final_idle_done", done, 0);

    push_sched(0, 1);
    valid0_cnt = 0; run0_cycles = 0; done0_cnt = 0;
    start0 = 1'b1;
    tick(1'b0, 1'b0);
    start0 = 1'b0;
    for (int c = 0; c < 200 && done0_cnt == 0; c++) tick(1'b0, 1'b0);
    chk("p0_done_seen", done0_cnt, 1);
    chk("p0_steps", valid0_cnt, 24);
    chk("p0_run_cycles", run0_cycles, 24);
    chk("p0_queue_left", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
